// File: rtl/mpu_window_capture.sv
// Motion-onset window capture: detects onset on the sample stream, captures N_SAMPLES samples,
// then presents them on `mpu` with `mov` held. Define MPU_TIMEOUT_EN to enable the capture timeout.
module mpu_window_capture #(
    parameter int          N_SAMPLES       = 30,
    parameter int          SAMPLE_W        = 32,
    parameter int unsigned MOV_THRESH      = 1000,
    parameter int          HOLD_CYCLES     = 3,
    parameter int          COOLDOWN_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES  = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_valid,
    input  logic signed [SAMPLE_W-1:0]      sample_data,
    input  logic [4:0]                      ldr_in,
    output logic [N_SAMPLES*SAMPLE_W-1:0]   mpu,
    output logic [4:0]                      ldr_out,
    output logic                            mov,
    output logic                            busy,
    output logic                            drop,
    output logic                            abort
);
    localparam int CNT_W  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CD_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [SAMPLE_W:0] THRESH    = (SAMPLE_W+1)'(MOV_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PRESENT, S_COOLDOWN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [CD_W-1:0]       cd_q, cd_d;
    logic [SAMPLE_W-1:0]   slot_q [N_SAMPLES];
    logic [SAMPLE_W-1:0]   slot_d [N_SAMPLES];
    logic [SAMPLE_W-1:0]   ref_q, ref_d;
    logic                  ref_valid_q, ref_valid_d;
    logic [4:0]            ldr_q, ldr_d;
    logic                  mov_q, mov_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;
    logic [SAMPLE_W:0]     diff;
    logic [SAMPLE_W:0]     diff_mag;
    logic                  onset;

    // One extra bit keeps the difference of two extreme samples from wrapping.
    always_comb begin
        diff     = {sample_data[SAMPLE_W-1], sample_data} - {ref_q[SAMPLE_W-1], ref_q};
        diff_mag = diff[SAMPLE_W] ? (~diff + 1'b1) : diff;
        onset    = ref_valid_q && (diff_mag > THRESH);
    end

`ifdef MPU_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            abort_q, abort_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        cd_d        = cd_q;
        slot_d      = slot_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        ldr_d       = ldr_q;
        mov_d       = mov_q;
        drop_d      = 1'b0;
`ifdef MPU_TIMEOUT_EN
        to_d        = to_q;
        abort_d     = 1'b0;
`endif
        // Every strobe refreshes the reference, including discarded ones.
        if (sample_valid) begin
            ref_d       = sample_data;
            ref_valid_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (sample_valid && onset) begin
                    slot_d[0] = sample_data;
`ifdef MPU_TIMEOUT_EN
                    to_d = '0;
`endif
                    if (N_SAMPLES == 1) begin
                        ldr_d   = ldr_in;
                        mov_d   = 1'b1;
                        hold_d  = '0;
                        state_d = S_PRESENT;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (sample_valid) begin
                    slot_d[cnt_q] = sample_data;
`ifdef MPU_TIMEOUT_EN
                    to_d = '0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        ldr_d   = ldr_in;
                        mov_d   = 1'b1;
                        hold_d  = '0;
                        cnt_d   = '0;
                        state_d = S_PRESENT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef MPU_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    abort_d = 1'b1;
                    to_d    = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_PRESENT: begin
                drop_d = sample_valid;
                if (hold_q == HOLD_LAST) begin
                    mov_d   = 1'b0;
                    cd_d    = '0;
                    state_d = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                drop_d = sample_valid;
                if (cd_q == CD_LAST) state_d = S_IDLE;
                else                 cd_d    = cd_q + 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            cd_q        <= '0;
            slot_q      <= '{default: '0};
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            ldr_q       <= '0;
            mov_q       <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            cd_q        <= cd_d;
            slot_q      <= slot_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            ldr_q       <= ldr_d;
            mov_q       <= mov_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

`ifdef MPU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            to_q    <= to_d;
            abort_q <= abort_d;
        end
    end
    assign abort = abort_q;
`else
    // Timeout length only matters when the timeout is built in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
    assign abort = 1'b0;
`endif

    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_pack
        assign mpu[SAMPLE_W*gi +: SAMPLE_W] = slot_q[gi];
    end

    assign ldr_out = ldr_q;
    assign mov     = mov_q;
    assign busy    = busy_q;
    assign drop    = drop_q;
endmodule

// File: doc/mpu_window_capture.md
Name: mpu_window_capture

Overview:
- Upstream stage of the gesture recognizer.
- Watches the accelerometer sample stream and detects motion onset against a threshold.
- On motion onset, captures a window of N_SAMPLES consecutive samples and packs them into the flat `mpu` bus.
- Then raises `mov` for a fixed hold period with `mpu` and `ldr_out` stable, so the recognizer's registered stages can consume one coherent window.

Parameters:
- N_SAMPLES, 30, samples per window; `mpu` width = N_SAMPLES*SAMPLE_W (960 by default).
- SAMPLE_W, 32, signed sample width.
- MOV_THRESH, 1000, unsigned magnitude; onset when |sample − previous sample| > MOV_THRESH.
- HOLD_CYCLES, 3, cycles `mov` stays high per window (≥1).
- COOLDOWN_CYCLES, 16, idle cycles after hold before re-arming (≥0).
- TIMEOUT_CYCLES, 1000000, max cycles between samples during capture (feature-gated).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe: sample_data is valid.
- sample_data  in  SAMPLE_W  signed accelerometer sample.
- ldr_in  in  5  live LDR flex-sensor bits.
- mpu  out  N_SAMPLES*SAMPLE_W  packed window; slot i at [SAMPLE_W*i+SAMPLE_W-1 : SAMPLE_W*i]; slot 0 is the trigger sample.
- ldr_out  out  5  ldr_in latched with the last window sample.
- mov  out  1  window valid, held HOLD_CYCLES cycles.
- busy  out  1  high in CAPTURE, PRESENT and COOLDOWN.
- drop  out  1  one-cycle pulse: sample arrived in PRESENT or COOLDOWN and was discarded.
- abort  out  1  one-cycle pulse on capture timeout; tied 0 when the feature is absent.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - mpu=0, ldr_out=0, mov=0, busy=0, drop=0, abort=0.
  - Sample counter=0; the previous-sample reference is marked invalid.
  - Reset asserted mid-capture or mid-hold discards the window. No `mov` is produced for it.
- All outputs are registered.
- Reference tracking:
  - Every accepted sample_valid in any state loads the reference and sets it valid.
  - This includes samples that are dropped.
- Onset detection:
  - diff = sample_data − reference, computed at SAMPLE_W+1 bits (no overflow).
  - |diff| is compared strictly greater than MOV_THRESH.
  - A sample with an invalid reference never triggers.
- IDLE:
  - sample_valid with onset: write sample to slot 0, counter←1, go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - Each sample_valid writes slot[counter], then counter increments.
  - The edge that writes slot N_SAMPLES−1 also latches ldr_out←ldr_in, sets mov←1 and goes to PRESENT.
  - `mov` is therefore visible the cycle after the last sample strobe.
  - No onset test is made inside CAPTURE.
- PRESENT:
  - mov=1 for exactly HOLD_CYCLES consecutive cycles.
  - mpu and ldr_out do not change.
  - Then mov←0 and go to COOLDOWN; if COOLDOWN_CYCLES=0, go directly to IDLE.
- COOLDOWN:
  - Stay COOLDOWN_CYCLES cycles, then go to IDLE.
  - A sample arriving on the exit cycle is treated as a COOLDOWN sample (dropped).
- Dropped samples:
  - sample_valid in PRESENT or COOLDOWN pulses drop the next cycle and updates the reference only.
- mpu after a window:
  - mpu keeps the last window until the next capture overwrites slots progressively.
  - Slots are valid only while mov=1.
- Back-to-back strobes (sample_valid high every cycle) are fully supported; every strobe is one sample.

Optional Feature:
- Macro: MPU_TIMEOUT_EN.
- Defined:
  - In CAPTURE, a counter resets on each sample_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, pulse abort for 1 cycle, counter←0, go to IDLE, and do not assert mov.
  - Partial slots remain in mpu.
  - The reference keeps the last sample.
- Not defined:
  - CAPTURE waits indefinitely.
  - abort is constant 0 and no timeout counter is synthesized.

Test Plan:
1. Reset/quiet stream:
   - Stimulus: reset low 2 cycles, then 50 samples all equal to 500.
   - Required: mov never rises, busy=0, mpu=0, drop=0.
2. Full window:
   - Stimulus: samples 0, then 2000, then 29 more valued 2001..2029; ldr_in=5'b00110 on the last strobe.
   - Required: mpu slot0=2000, slot29=2029; ldr_out=5'b00110; mov high exactly 3 cycles, starting the cycle after the 30th strobe.
3. Threshold boundary:
   - Stimulus: reference 0, next sample 1000, then −1001.
   - Required: 1000 does not trigger; −1001 (diff magnitude 2001 vs reference 1000) triggers; slot0=−1001.
4. Drops and re-arm:
   - Stimulus: continuous strobes after a window completes.
   - Required: one drop pulse per strobe during the 3+16 PRESENT/COOLDOWN cycles; the next capture starts only from IDLE with an onset relative to the last dropped sample.
5. Reset mid-capture:
   - Stimulus: reset low after 12 captured samples.
   - Required: state IDLE, mpu=0, mov stays 0; the first post-reset sample cannot trigger.
6. With MPU_TIMEOUT_EN, TIMEOUT_CYCLES=100:
   - Stimulus: trigger onset, send 5 samples, then stop.
   - Required: abort pulses at cycle 100 after the last strobe, state returns to IDLE, mov stays 0.
   - Without the macro: busy stays 1.
